// File: rtl/sram_bus_slave.sv
// sram_bus_slave: word-addressed single-port memory slave with fixed-latency two-phase handshake
module sram_bus_slave #(
    parameter int                   BUS_WIDTH  = 32,
    parameter int                   DATA_WIDTH = 32,
    parameter int                   MASK_WIDTH = DATA_WIDTH / 8,
    parameter int                   DEPTH      = 4096,
    parameter logic [BUS_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                   LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_req_i,
    input  logic                  mem_we_i,
    input  logic [BUS_WIDTH-1:0]  mem_address_i,
    input  logic [DATA_WIDTH-1:0] mem_wdata_i,
    input  logic [MASK_WIDTH-1:0] mem_wmask_i,
    output logic                  mem_addr_ok_o,
    output logic                  mem_data_ok_o,
    output logic [DATA_WIDTH-1:0] mem_rdata_o,
    output logic                  mem_err_o
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic err_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic ready, accept, in_range;
    logic [BUS_WIDTH:0] off;
    logic [AW-1:0] idx;
    // One extra bit keeps the borrow, so addresses below the base never wrap into range
    assign off = {1'b0, mem_address_i} - {1'b0, BASE_ADDR};
    assign in_range = !off[BUS_WIDTH] && off < (BUS_WIDTH + 1)'(4 * DEPTH);
    assign idx = AW'(off >> 2);
    assign ready = state_q == IDLE || cnt_q == 4'd0;
    assign mem_addr_ok_o = mem_req_i && ready;
    assign accept = mem_addr_ok_o;
    assign mem_data_ok_o = state_q == BUSY && cnt_q == 4'd0;
    assign mem_rdata_o = mem_data_ok_o ? rdata_q : '0;
    assign mem_err_o = mem_data_ok_o && err_q;
    always_comb begin
        state_d = ready ? (accept ? BUSY : IDLE) : state_q;
        cnt_d = accept ? CNT_INIT : (cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            rdata_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            if (accept) begin
                rdata_q <= (!mem_we_i && in_range) ? mem_q[idx] : '0;
                err_q <= !in_range;
            end
        end
    end
    // Writes land at the end of the accept cycle, so a read accepted later sees them directly
    always_ff @(posedge clk) begin
        if (accept && mem_we_i && in_range)
            for (int b = 0; b < MASK_WIDTH; b++)
                if (mem_wmask_i[b]) mem_q[idx][8*b +: 8] <= mem_wdata_i[8*b +: 8];
    end
endmodule

// File: tb/tb_sram_bus_slave.sv
// tb_sram_bus_slave: directed and random checks of three slaves (latency 1, 3, 4) against a word-array model
module tb_sram_bus_slave;
    localparam int DEPTH = 256;
    localparam logic [31:0] BASE = 32'h100;
    localparam logic [31:0] LIMIT = BASE + 4 * DEPTH;
    logic clk, rst_n;
    logic req [3], we [3], addr_ok [3], data_ok [3], err [3];
    logic [31:0] addr [3], wdata [3], rdata [3];
    logic [3:0] wmask [3];
    bit [31:0] mdl [int];
    int checks, errors;
    logic [31:0] got;
    logic [31:0] oor [3];
    logic [31:0] a3 [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sram_bus_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(g == 0 ? 1 : g == 1 ? 3 : 4)) dut (
            .clk(clk), .rst_n(rst_n), .mem_req_i(req[g]), .mem_we_i(we[g]), .mem_address_i(addr[g]),
            .mem_wdata_i(wdata[g]), .mem_wmask_i(wmask[g]), .mem_addr_ok_o(addr_ok[g]),
            .mem_data_ok_o(data_ok[g]), .mem_rdata_o(rdata[g]), .mem_err_o(err[g]));
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat(input int d);
        return d == 0 ? 1 : d == 1 ? 3 : 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: a word array indexed by (address - base)/4, updated byte by byte
    task automatic model(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] m, output logic [31:0] er, output logic ee);
        longint la;
        bit inr;
        int key;
        la = a;
        inr = la >= longint'(BASE) && la < longint'(LIMIT);
        er = 0;
        ee = !inr;
        if (inr) begin
            key = d * 1024 + int'((la - longint'(BASE)) / 4);
            if (w) begin
                for (int b = 0; b < 4; b++) if (m[b]) mdl[key][8*b +: 8] = wd[8*b +: 8];
            end else er = mdl[key];
        end
    endtask

    task automatic access(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] m, output logic [31:0] r);
        logic [31:0] er;
        logic ee;
        model(d, w, a, wd, m, er, ee);
        @(posedge clk); #1;
        req[d] = 1; we[d] = w; addr[d] = a; wdata[d] = wd; wmask[d] = m;
        @(negedge clk);
        chk("addr_ok", addr_ok[d], 1);
        chk("data_ok_at_accept", data_ok[d], 0);
        @(posedge clk); #1;
        req[d] = 0; we[d] = 1'($urandom); addr[d] = $urandom; wdata[d] = $urandom; wmask[d] = 4'($urandom);
        for (int k = 1; k < lat(d); k++) begin
            @(negedge clk);
            chk("data_ok_early", data_ok[d], 0);
            chk("rdata_not_valid", rdata[d], 0);
        end
        @(negedge clk);
        chk("data_ok", data_ok[d], 1);
        chk("rdata", rdata[d], er);
        chk("err", err[d], ee);
        r = rdata[d];
        @(negedge clk);
        chk("data_ok_single", data_ok[d], 0);
        chk("err_idle", err[d], 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 0;
        for (int d = 0; d < 3; d++) begin
            req[d] = 0; we[d] = 0; addr[d] = 0; wdata[d] = 0; wmask[d] = 0;
        end
        oor[0] = BASE - 4; oor[1] = LIMIT; oor[2] = 32'hFFFF_FFFC;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_data_ok", data_ok[d], 0);
            chk("rst_rdata", rdata[d], 0);
            chk("rst_err", err[d], 0);
            chk("rst_addr_ok_noreq", addr_ok[d], 0);
        end
        @(posedge clk); #1;
        rst_n = 1;

        // Single accesses and byte masks at latency 1
        access(0, 1, 32'h100, 32'hDEADBEEF, 4'hF, got);
        chk("t1_write_rdata", got, 0);
        access(0, 0, 32'h100, 0, 0, got);
        chk("t1_read", got, 32'hDEADBEEF);
        access(0, 1, 32'h104, 32'hAABBCCDD, 4'hF, got);
        access(0, 1, 32'h104, 32'h11223344, 4'b0101, got);
        access(0, 0, 32'h104, 0, 0, got);
        chk("t2_mask", got, 32'hAA22CC44);
        access(0, 1, 32'h104, 32'h55555555, 4'h0, got);
        access(0, 0, 32'h104, 0, 0, got);
        chk("t2_mask_zero", got, 32'hAA22CC44);

        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 8; i++) access(d, 1, BASE + 4 * i, $urandom, 4'hF, got);
            access(d, 1, LIMIT - 4, $urandom, 4'hF, got);
        end

        // Out of range: read returns 0 with err, dropped write leaves the last word alone
        access(0, 0, LIMIT, 0, 0, got);
        chk("t4_oor_rdata", got, 0);
        access(0, 1, LIMIT, 32'hCAFEF00D, 4'hF, got);
        access(0, 0, LIMIT - 4, 0, 0, got);
        chk("t4_last_word", got, mdl[DEPTH - 1]);
        access(0, 0, BASE - 4, 0, 0, got);
        access(0, 0, 32'hFFFF_FFFC, 0, 0, got);

        // Write then read of the same word accepted in the write's response cycle
        model(0, 1, 32'h200, 32'h12345678, 4'hF, got, got[0]);
        @(posedge clk); #1;
        req[0] = 1; we[0] = 1; addr[0] = 32'h200; wdata[0] = 32'h12345678; wmask[0] = 4'hF;
        @(negedge clk);
        chk("t5_wr_addr_ok", addr_ok[0], 1);
        @(posedge clk); #1;
        we[0] = 0; wdata[0] = $urandom;
        @(negedge clk);
        chk("t5_wr_data_ok", data_ok[0], 1);
        chk("t5_wr_rdata", rdata[0], 0);
        chk("t5_rd_addr_ok", addr_ok[0], 1);
        @(posedge clk); #1;
        req[0] = 0;
        @(negedge clk);
        chk("t5_rd_data_ok", data_ok[0], 1);
        chk("t5_rd_rdata", rdata[0], 32'h12345678);

        // Back-to-back reads at latency 3 with request held high; address wiggles while busy
        for (int i = 0; i < 3; i++) a3[i] = BASE + 4 * (i * 2 + 1);
        @(posedge clk); #1;
        for (int k = 0; k <= 10; k++) begin
            req[1] = k <= 6;
            we[1] = 0;
            addr[1] = (k % 3 == 0 && k <= 6) ? a3[k / 3] : BASE + 4 * $urandom_range(0, 7);
            @(negedge clk);
            chk("t3_addr_ok", addr_ok[1], 32'(k % 3 == 0 && k <= 6));
            chk("t3_data_ok", data_ok[1], 32'(k % 3 == 0 && k > 0));
            if (k % 3 == 0 && k > 0) chk("t3_rdata", rdata[1], mdl[1024 + int'((a3[k / 3 - 1] - BASE) / 4)]);
            @(posedge clk); #1;
        end
        req[1] = 0;

        // Reset one cycle after a read is accepted at latency 4
        access(2, 1, 32'h300, 32'h0BADCAFE, 4'hF, got);
        @(posedge clk); #1;
        req[2] = 1; we[2] = 0; addr[2] = 32'h300;
        @(negedge clk);
        chk("t6_addr_ok", addr_ok[2], 1);
        @(posedge clk); #1;
        req[2] = 0;
        rst_n = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("t6_no_data_ok", data_ok[2], 0);
            @(posedge clk); #1;
            if (k == 2) rst_n = 1;
        end
        access(2, 0, 32'h300, 0, 0, got);
        chk("t6_committed", got, 32'h0BADCAFE);

        // Random traffic on all three slaves
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 30; n++) begin
                int r;
                logic [31:0] a;
                r = $urandom_range(0, 9);
                a = r < 8 ? BASE + 4 * $urandom_range(0, 7) + $urandom_range(0, 3)
                  : r == 8 ? LIMIT - 4 : oor[$urandom_range(0, 2)];
                access(d, 1'($urandom), a, $urandom, 4'($urandom), got);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
